// File: rtl/fc_act_dequant_reader.sv
// fc_act_dequant_reader: unpacks 8-bit FC activations from SRAM words and rescales them to the 32-bit accumulator domain
// Ports: clk/srstn (sync active-low reset); start/fc_state/base_addr/num_words job request;
// sram_en/sram_raddr/sram_rdata one-cycle-latency SRAM read; out_valid/out_ready/out_data/out_last beat stream;
// busy/done job status; range_err sticky FC1 range error, live only when FC1_RANGE_CHK_EN is defined.
module fc_act_dequant_reader #(
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 10,
  parameter int FC1_SHIFT = 6,
  parameter int FC2_SHIFT = 5
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              start,
  input  logic              fc_state,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [31:0]       sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2, EMIT = 2'd3;
  logic [1:0] state, lane;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] words_left;
  logic fc_mode;
  logic [31:0] word_buf, ext, deq;
  logic [7:0] cur_byte;
  logic fire, last_lane, oor;
  assign cur_byte  = word_buf[{lane, 3'b000} +: 8];
  assign ext       = {{24{cur_byte[7]}}, cur_byte};
  assign deq       = fc_mode ? ext << FC2_SHIFT : ext << FC1_SHIFT;
  assign out_valid = state == EMIT;
  assign busy      = state != IDLE;
  assign fire      = out_valid && out_ready;
  assign last_lane = lane == 2'd3;
  assign out_last  = out_valid && last_lane && words_left == CNT_W'(1);
  assign out_data  = (out_valid && !oor) ? deq : '0;
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state      <= IDLE;
      lane       <= '0;
      addr       <= '0;
      words_left <= '0;
      fc_mode    <= 1'b0;
      word_buf   <= '0;
      sram_en    <= 1'b0;
      sram_raddr <= '0;
      done       <= 1'b0;
    end else begin
      sram_en <= 1'b0;
      done    <= 1'b0;
      if (state == IDLE && start) begin
        fc_mode    <= fc_state;
        addr       <= base_addr;
        words_left <= num_words;
        if (num_words != '0) begin
          state      <= FETCH;
          sram_en    <= 1'b1;
          sram_raddr <= base_addr;
        end else begin
          done <= 1'b1;
        end
      end
      if (state == FETCH) state <= WAIT;
      if (state == WAIT) begin
        word_buf <= sram_rdata;
        lane     <= '0;
        state    <= EMIT;
      end
      if (fire) begin
        lane <= lane + 2'd1;
        if (last_lane) begin
          words_left <= words_left - CNT_W'(1);
          if (words_left != CNT_W'(1)) begin
            addr       <= addr + ADDR_W'(1);
            sram_raddr <= addr + ADDR_W'(1);
            sram_en    <= 1'b1;
            state      <= FETCH;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end
`ifdef FC1_RANGE_CHK_EN
  // FC1 data is unsigned 0..127, so bit7 set means the byte is out of range and is clamped to zero
  assign oor = out_valid && !fc_mode && cur_byte[7];
  always_ff @(posedge clk) begin
    if (!srstn) range_err <= 1'b0;
    else if (state == IDLE && start) range_err <= 1'b0;
    else if (fire && oor) range_err <= 1'b1;
  end
`else
  assign oor       = 1'b0;
  assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_fc_act_dequant_reader.sv
// tb_fc_act_dequant_reader: directed self-checking bench for fc_act_dequant_reader
module tb_fc_act_dequant_reader;
  logic clk, srstn, start, fc_state, sram_en, out_valid, out_ready, out_last, busy, done, range_err;
  logic [9:0] base_addr, num_words, sram_raddr;
  logic [31:0] sram_rdata, out_data;
  logic [31:0] mem [0:1023];
  logic [9:0] rd_a [0:31];
  int rd_n = 0;
  int n_chk = 0, n_err = 0;
  int got_n, first_valid_cyc, done_cyc, stall_bad, r0, done_seen;
  logic [31:0] got_d [0:15];
  logic got_l [0:15];

  fc_act_dequant_reader dut (
    .clk(clk), .srstn(srstn), .start(start), .fc_state(fc_state), .base_addr(base_addr),
    .num_words(num_words), .sram_en(sram_en), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_raddr];
      if (rd_n < 32) rd_a[rd_n] <= sram_raddr;
      rd_n <= rd_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " sram_en"}, 32'(sram_en), 32'd0);
    chk({tag, " sram_raddr"}, 32'(sram_raddr), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"}, out_data, 32'd0);
    chk({tag, " out_last"}, 32'(out_last), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " range_err"}, 32'(range_err), 32'd0);
  endtask

  // Steps cycles after a start edge, collecting accepted beats until done or the cycle budget runs out.
  // bp=1 drives out_ready with the repeating pattern 1,0,0,1.
  task automatic run(input int maxc, input bit bp);
    logic [31:0] prev_d;
    logic prev_l;
    bit stalled;
    got_n = 0; first_valid_cyc = -1; done_cyc = -1; stall_bad = 0; stalled = 0;
    prev_d = '0; prev_l = 1'b0;
    for (int c = 1; c <= maxc && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) done_cyc = c;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (stalled && (out_data !== prev_d || out_last !== prev_l)) stall_bad++;
      out_ready = bp ? (c % 4 == 1 || c % 4 == 0) : 1'b1;
      if (out_valid && out_ready && got_n < 16) begin
        got_d[got_n] = out_data;
        got_l[got_n] = out_last;
        got_n++;
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    srstn = 1'b0; start = 1'b0; fc_state = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
    sram_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5]  = 32'h7F400100;
    mem[9]  = 32'h80FF7F01;
    mem[20] = 32'h04030201;
    mem[21] = 32'h08070605;
    mem[22] = 32'h0C0B0A09;
    mem[30] = 32'h01010101;
    mem[50] = 32'h04030201;
    mem[60] = 32'h7F400100;
    mem[70] = 32'h00000080;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    srstn = 1'b1;

    // FC1 single word
    r0 = rd_n;
    start = 1'b1; fc_state = 1'b0; base_addr = 10'd5; num_words = 10'd1;
    run(20, 1'b0);
    chk("t1 beats", 32'(got_n), 32'd4);
    chk("t1 d0", got_d[0], 32'd0);
    chk("t1 d1", got_d[1], 32'd64);
    chk("t1 d2", got_d[2], 32'd4096);
    chk("t1 d3", got_d[3], 32'd8128);
    chk("t1 last", {28'd0, got_l[3], got_l[2], got_l[1], got_l[0]}, 32'b1000);
    chk("t1 first_valid", 32'(first_valid_cyc), 32'd3);
    chk("t1 done_cyc", 32'(done_cyc), 32'd7);
    chk("t1 reads", 32'(rd_n - r0), 32'd1);
    chk("t1 raddr", 32'(rd_a[r0]), 32'd5);
    @(posedge clk); #1;
    chk("t1 done pulse", 32'(done), 32'd0);
    chk("t1 idle", 32'(busy), 32'd0);

    // FC2 signed word
    start = 1'b1; fc_state = 1'b1; base_addr = 10'd9; num_words = 10'd1;
    run(20, 1'b0);
    chk("t2 beats", 32'(got_n), 32'd4);
    chk("t2 d0", got_d[0], 32'd32);
    chk("t2 d1", got_d[1], 32'd4064);
    chk("t2 d2", got_d[2], 32'hFFFFFFE0);
    chk("t2 d3", got_d[3], 32'hFFFFF000);

    // backpressure over three FC2 words: byte k (1..12) dequantizes to 32*k
    r0 = rd_n;
    start = 1'b1; fc_state = 1'b1; base_addr = 10'd20; num_words = 10'd3;
    run(200, 1'b1);
    chk("t3 beats", 32'(got_n), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t3 d%0d", i), got_d[i], 32'((i + 1) * 32));
      chk($sformatf("t3 last%0d", i), 32'(got_l[i]), (i == 11) ? 32'd1 : 32'd0);
    end
    chk("t3 stall stable", 32'(stall_bad), 32'd0);
    chk("t3 done seen", 32'(done_cyc > 0), 32'd1);
    chk("t3 reads", 32'(rd_n - r0), 32'd3);
    chk("t3 raddr0", 32'(rd_a[r0]), 32'd20);
    chk("t3 raddr1", 32'(rd_a[r0 + 1]), 32'd21);
    chk("t3 raddr2", 32'(rd_a[r0 + 2]), 32'd22);

    // num_words = 0
    r0 = rd_n;
    start = 1'b1; fc_state = 1'b0; base_addr = 10'd100; num_words = 10'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4 zero done", 32'(done), 32'd1);
    chk("t4 zero busy", 32'(busy), 32'd0);
    chk("t4 zero sram_en", 32'(sram_en), 32'd0);
    @(posedge clk); #1;
    chk("t4 zero done drop", 32'(done), 32'd0);
    chk("t4 zero reads", 32'(rd_n - r0), 32'd0);

    // start while busy is ignored
    r0 = rd_n;
    start = 1'b1; fc_state = 1'b0; base_addr = 10'd30; num_words = 10'd1;
    @(posedge clk); #1;
    chk("t4 busy", 32'(busy), 32'd1);
    start = 1'b1; fc_state = 1'b1; base_addr = 10'd40; num_words = 10'd3;
    run(20, 1'b0);
    chk("t4 ign beats", 32'(got_n), 32'd4);
    chk("t4 ign d0", got_d[0], 32'd64);
    chk("t4 ign last", 32'(got_l[3]), 32'd1);
    chk("t4 ign done_cyc", 32'(done_cyc), 32'd6);
    chk("t4 ign reads", 32'(rd_n - r0), 32'd1);
    chk("t4 ign raddr", 32'(rd_a[r0]), 32'd30);
    @(posedge clk); #1;
    chk("t4 ign idle", 32'(busy), 32'd0);

    // reset while emitting lane 2
    start = 1'b1; fc_state = 1'b0; base_addr = 10'd50; num_words = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t5 pre valid", 32'(out_valid), 32'd1);
    chk("t5 pre lane2", out_data, 32'd192);
    srstn = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("t5 reset");
    srstn = 1'b1;
    done_seen = 0;
    repeat (6) begin @(posedge clk); #1; done_seen += int'(done); end
    chk("t5 no done", 32'(done_seen), 32'd0);
    chk("t5 quiet", 32'(busy), 32'd0);
    r0 = rd_n;
    start = 1'b1; fc_state = 1'b0; base_addr = 10'd60; num_words = 10'd1;
    run(20, 1'b0);
    chk("t5 rerun beats", 32'(got_n), 32'd4);
    chk("t5 rerun d1", got_d[1], 32'd64);
    chk("t5 rerun d3", got_d[3], 32'd8128);
    chk("t5 rerun done_cyc", 32'(done_cyc), 32'd7);
    chk("t5 rerun reads", 32'(rd_n - r0), 32'd1);
    chk("t5 rerun raddr", 32'(rd_a[r0]), 32'd60);

    // FC1 out-of-range byte
    start = 1'b1; fc_state = 1'b0; base_addr = 10'd70; num_words = 10'd1;
    run(20, 1'b0);
    chk("t6 beats", 32'(got_n), 32'd4);
`ifdef FC1_RANGE_CHK_EN
    chk("t6 d0", got_d[0], 32'd0);
    chk("t6 range_err", 32'(range_err), 32'd1);
`else
    chk("t6 d0", got_d[0], 32'hFFFFE000);
    chk("t6 range_err", 32'(range_err), 32'd0);
`endif
    chk("t6 d1", got_d[1], 32'd0);
    chk("t6 done_cyc", 32'(done_cyc), 32'd7);
    start = 1'b1; fc_state = 1'b1; base_addr = 10'd9; num_words = 10'd1;
    run(20, 1'b0);
    chk("t6 err cleared", 32'(range_err), 32'd0);
    chk("t6 fc2 d3", got_d[3], 32'hFFFFF000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fc_act_dequant_reader.md
Name: fc_act_dequant_reader

Overview:
Reads packed 8-bit quantized FC activations from activation SRAM. Each 32-bit word holds four bytes. The block unpacks the bytes and rescales each one back into the 32-bit accumulator domain, inverting the FC1/FC2 requantization shift. It sits between the activation SRAM and the next FC layer's MAC array and streams one dequantized value per valid/ready beat.

Parameters:
ADDR_W, 10, SRAM word-address width
CNT_W, 10, width of the word-count input
FC1_SHIFT, 6, left-shift restoring FC1 scale
FC2_SHIFT, 5, left-shift restoring FC2 scale

Ports:
clk  input  1  clock, rising edge
srstn  input  1  synchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
fc_state  input  1  0 = FC1 (unsigned 0..127 data), 1 = FC2 (signed -128..127 data); latched on start
base_addr  input  ADDR_W  first SRAM word address; latched on start
num_words  input  CNT_W  number of words to read; latched on start
sram_en  output  1  SRAM read enable, registered
sram_raddr  output  ADDR_W  SRAM read address, registered
sram_rdata  input  32  read data, valid exactly 1 cycle after the sram_en cycle
out_valid  output  1  out_data valid
out_ready  input  1  downstream accept
out_data  output  32  signed dequantized value
out_last  output  1  high with the final beat of the job
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when the job completes
range_err  output  1  sticky FC1 range error (see Optional Feature)

Behaviour:
- Reset (srstn=0 at posedge) gives: state IDLE, sram_en=0, sram_raddr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, range_err=0, all internal counters 0.
- Reset mid-job aborts immediately. No further SRAM reads and no done pulse are produced.
- FSM states: IDLE, FETCH, WAIT, EMIT.
- IDLE:
  - start=1 with num_words>0: latch inputs, addr=base_addr, words_left=num_words, go to FETCH.
  - start=1 with num_words=0: done pulses the next cycle; no SRAM access; stay IDLE.
- FETCH (1 cycle): sram_en=1, sram_raddr=addr. Go to WAIT.
- WAIT (1 cycle): sram_en=0. sram_rdata is captured into word_buf at the end of the cycle. lane=0. Go to EMIT.
- EMIT:
  - out_valid=1; out_data = dequant(word_buf[8*lane+7:8*lane]). Byte lane 0 (LSB) goes first.
  - While out_ready=0, out_data and out_last hold stable.
  - On out_valid&&out_ready with lane<3: lane increments.
  - On out_valid&&out_ready with lane==3: words_left decrements.
    - If words remain: addr increments and the FSM goes to FETCH.
    - Otherwise: FSM goes to IDLE and done=1 for that next cycle.
- out_last=1 only in EMIT, lane==3, words_left==1.
- Latency: start sampled at edge 0 → sram_en high in cycle 1 → first out_valid in cycle 3.
- Throughput: 4 beats per 6 cycles at out_ready=1; no read prefetch.
- start while busy is ignored; latched parameters do not change.
- Dequant arithmetic, with the byte treated as signed 8-bit and sign-extended to 32 bits before shifting:
  - FC1: out_data = byte <<< FC1_SHIFT.
  - FC2: out_data = byte <<< FC2_SHIFT.
  - No rounding offset is applied. Results always fit in 32 bits.
- sram_raddr wraps modulo 2^ADDR_W at its top address; no error is raised.

Optional Feature:
Macro FC1_RANGE_CHK_EN.
- Defined:
  - In FC1 mode, a byte with bit7=1 is out of range. That beat outputs out_data=0, matching the FC1 zero clamp.
  - range_err sets on the accepted beat and stays high until reset or the next accepted start.
  - FC2 mode is never checked.
- Undefined:
  - No check; FC1 bytes are sign-extended and shifted as-is.
  - range_err is tied to 0.
  - The port list is unchanged.

Test Plan:
1. FC1 single word: base_addr=5, num_words=1, rdata=0x7F400100, out_ready=1.
   → exactly one read at addr 5; out_data = 0, 64, 4096, 8128; out_last on the 4th beat; done one cycle later; first out_valid 3 cycles after start.
2. FC2 signed word: rdata=0x80FF7F01.
   → out_data = 32, 4064, 0xFFFFFFE0, 0xFFFFF000.
3. Backpressure: 3 words, out_ready toggling 1,0,0,1…
   → no beat lost or duplicated; out_data stable while stalled; 12 beats total; addresses base, base+1, base+2.
4. Edge cases: num_words=0 → done pulse, sram_en never high. start during busy → ignored.
5. Reset mid-EMIT (lane 2): srstn low one cycle.
   → all outputs at reset values; no done; a new start runs cleanly.
6. FC1_RANGE_CHK_EN defined, FC1, rdata=0x00000080.
   → beat 0 out_data=0 and range_err=1, held through done.
   Same stimulus with the macro undefined → out_data=0xFFFFE000, range_err=0.
